// File: rtl/pgr_rsp_packer_32bit_if.sv
// Response-side bus of the UART-to-APB bridge return path: completed APB
// transaction in, byte stream out toward the UART TX FIFO.
interface pgr_rsp_packer_32bit_if;
    logic        rsp_valid;
    logic        rsp_we;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_fifo_full;
    logic        tx_done;

    // Upstream/FIFO side: drives the response and the FIFO full flag.
    modport master (
        output rsp_valid, rsp_we, rsp_err, rsp_data, tx_fifo_full,
        input  rsp_ready, tx_data, tx_data_valid, tx_done
    );

    // Packer side.
    modport slave (
        input  rsp_valid, rsp_we, rsp_err, rsp_data, tx_fifo_full,
        output rsp_ready, tx_data, tx_data_valid, tx_done
    );
endinterface

// File: rtl/pgr_rsp_packer_32bit.sv
// Response packer: captures one finished APB transaction and serialises it
// into the UART TX FIFO as a byte frame (header first, then LSB-first data
// for reads). Single-entry; new responses are taken only while idle.
module pgr_rsp_packer_32bit #(
    parameter bit         WR_ACK_EN = 1'b1,
    parameter logic [7:0] HDR_R     = 8'h72,
    parameter logic [7:0] HDR_W     = 8'h77,
    parameter logic [7:0] HDR_E     = 8'h65
) (
    input  logic                         clk,
    input  logic                         rst,
    pgr_rsp_packer_32bit_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        B0   = 3'd2,
        B1   = 3'd3,
        B2   = 3'd4,
        B3   = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] data_q;
    logic        we_q;
    logic        err_q;
    logic [7:0]  hdr_q;
    logic        tx_done_q;
    logic [7:0]  tx_data_c;
    logic        emit;
    logic        tx_fire;

    // A byte goes out whenever we are in an emit state and the FIFO has room;
    // reset kills the strobe in its own cycle so no partial tail is written.
    assign emit    = (state != IDLE);
    assign tx_fire = emit & ~bus.tx_fifo_full & ~rst;

    // Output byte select: header first, then captured data LSB first.
    always_comb begin
        tx_data_c = 8'h00;
        case (state)
            HDR:     tx_data_c = hdr_q;
            B0:      tx_data_c = data_q[7:0];
            B1:      tx_data_c = data_q[15:8];
            B2:      tx_data_c = data_q[23:16];
            B3:      tx_data_c = data_q[31:24];
            default: tx_data_c = 8'h00;
        endcase
    end

    assign bus.rsp_ready     = (state == IDLE);
    assign bus.tx_data       = tx_data_c;
    assign bus.tx_data_valid = tx_fire;
    assign bus.tx_done       = tx_done_q;

    // Frame FSM: capture in IDLE, then step one byte per accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= 32'h0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            hdr_q     <= 8'h00;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rsp_valid) begin
                        data_q <= bus.rsp_data;
                        we_q   <= bus.rsp_we;
                        err_q  <= bus.rsp_err;
                        if (bus.rsp_err) begin
                            // Errors always answer with a lone error byte.
                            hdr_q <= HDR_E;
                            state <= HDR;
                        end else if (bus.rsp_we) begin
                            if (WR_ACK_EN) begin
                                hdr_q <= HDR_W;
                                state <= HDR;
                            end else begin
                                // Silent write: nothing to send, just signal completion.
                                tx_done_q <= 1'b1;
                            end
                        end else begin
                            hdr_q <= HDR_R;
                            state <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (tx_fire) begin
                        if (we_q | err_q) begin
                            state     <= IDLE;
                            tx_done_q <= 1'b1;
                        end else begin
                            state <= B0;
                        end
                    end
                end
                B0: if (tx_fire) state <= B1;
                B1: if (tx_fire) state <= B2;
                B2: if (tx_fire) state <= B3;
                B3: begin
                    if (tx_fire) begin
                        state     <= IDLE;
                        tx_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
